// File: rtl/io_console_pkg.sv
// Purpose: shared widths, byte type and helpers for the io_console slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`include "defines.vh"

package io_console_pkg;

    localparam int WORD_W         = `WORD_SIZE;
    localparam int BYTE_W         = `IO_BYTE_W;
    localparam int DEF_FIFO_DEPTH = `IO_FIFO_DEPTH_DEF;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    // Widen a host byte into a CPU word with zeros above the byte.
    function automatic word_t zext_byte(input byte_t b);
        return {{(WORD_W-BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/io_console_if.sv
// Purpose: bundles the CPU access port and the host RX/TX byte streams.
// Latency: n/a (wires only).
// Backpressure: rx_ready/tx_ready valid-ready handshakes, io_busy retry for the CPU.
interface io_console_if;
    import io_console_pkg::*;

    // CPU side
    logic  in_read;
    logic  out_write;
    word_t io_out;
    word_t io_in;
    logic  eof;
    logic  io_busy;

    // Host side
    byte_t rx_data;
    logic  rx_valid;
    logic  rx_ready;
    logic  rx_eof;
    byte_t tx_data;
    logic  tx_valid;
    logic  tx_ready;

    // Driver of the console: CPU and host.
    modport master (
        output in_read, out_write, io_out, rx_data, rx_valid, rx_eof, tx_ready,
        input  io_in, eof, io_busy, rx_ready, tx_data, tx_valid
    );

    // The console itself.
    modport slave (
        input  in_read, out_write, io_out, rx_data, rx_valid, rx_eof, tx_ready,
        output io_in, eof, io_busy, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/defines.vh
`ifndef IO_CONSOLE_DEFINES_VH
`define IO_CONSOLE_DEFINES_VH

// CPU word width seen on io_in / io_out.
`define WORD_SIZE 16
// Host-side byte width.
`define IO_BYTE_W 8
// Default number of entries in each byte FIFO (power of two, >= 2).
`define IO_FIFO_DEPTH_DEF 4

`endif

// File: rtl/io_console_byte_fifo.sv
// Purpose: small circular byte FIFO with occupancy counter and combinational head.
// Latency: push visible at head one cycle later; pop takes effect at the clock edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered.
module byte_fifo
    import io_console_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  byte_t push_dat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output byte_t head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // An empty FIFO presents zero so downstream never sees stale bytes.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/io_console.sv
// Purpose: CPU word console bridging host RX/TX byte streams through two byte FIFOs; optional echo via IO_CONSOLE_ECHO_EN.
// Latency: RX byte readable one cycle after acceptance; CPU write visible on tx one cycle later.
// Backpressure: rx_ready from registered RX occupancy and eof; io_busy asks the CPU to retry when RX empty or TX full.
module io_console
    import io_console_pkg::*;
#(
    parameter int IO_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    io_console_if.slave  bus
);
    logic  rx_full, rx_empty, rx_push, rx_pop;
    logic  tx_full, tx_empty, tx_push, tx_pop;
    byte_t rx_head, tx_head, tx_push_dat;
    logic  eof_seen;
    logic  rd_stall, wr_stall;
    logic  unused_io_hi;

    // Upper CPU word bits have nowhere to go on a byte stream.
    assign unused_io_hi = ^bus.io_out[WORD_W-1:BYTE_W];

    // Once the host has signalled end of input, no further bytes are taken.
    assign bus.rx_ready = !rx_full && !eof_seen;
    assign rx_push      = bus.rx_valid && bus.rx_ready;
    assign bus.io_in    = zext_byte(rx_head);
    assign bus.eof      = eof_seen && rx_empty;

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_head;
    assign tx_pop       = bus.tx_valid && bus.tx_ready;

    assign bus.io_busy  = rd_stall || wr_stall;

    // CPU access arbitration: decides pops, pushes and stall terms from registered occupancy.
    always_comb begin
        rx_pop      = 1'b0;
        rd_stall    = 1'b0;
        wr_stall    = 1'b0;
        tx_push     = 1'b0;
        tx_push_dat = bus.io_out[BYTE_W-1:0];
`ifdef IO_CONSOLE_ECHO_EN
        // Echo needs a TX slot, so a read stalls when TX is full; the echo
        // claims the TX push port ahead of any CPU write.
        rx_pop   = bus.in_read && !rx_empty && !tx_full;
        rd_stall = bus.in_read && (rx_empty ? !eof_seen : tx_full);
        wr_stall = bus.out_write && (tx_full || rx_pop);
        tx_push  = rx_pop || (bus.out_write && !wr_stall);
        if (rx_pop) tx_push_dat = rx_head;
`else
        rx_pop   = bus.in_read && !rx_empty;
        rd_stall = bus.in_read && rx_empty && !eof_seen;
        wr_stall = bus.out_write && tx_full;
        tx_push  = bus.out_write && !tx_full;
`endif
    end

    // Sticky end-of-input flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)             eof_seen <= 1'b0;
        else if (bus.rx_eof) eof_seen <= 1'b1;
    end

    byte_fifo #(.DEPTH(IO_FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (bus.rx_data),
        .pop      (rx_pop),
        .full     (rx_full),
        .empty    (rx_empty),
        .head     (rx_head)
    );

    byte_fifo #(.DEPTH(IO_FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (tx_push_dat),
        .pop      (tx_pop),
        .full     (tx_full),
        .empty    (tx_empty),
        .head     (tx_head)
    );
endmodule

// File: tb/tb_io_console.sv
// Purpose: directed and random checks of io_console against a queue-based reference model.
// Latency: one model step per clock; outputs sampled mid-cycle.
// Backpressure: model applies the console's stall and ready rules from queue sizes.
module tb_io_console;
    import io_console_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    io_console_if ifc ();

    io_console #(.IO_FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    byte_t rx_q[$];
    byte_t tx_q[$];
    bit    eof_seen_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        ifc.in_read   = 1'b0;
        ifc.out_write = 1'b0;
        ifc.io_out    = '0;
        ifc.rx_data   = '0;
        ifc.rx_valid  = 1'b0;
        ifc.rx_eof    = 1'b0;
        ifc.tx_ready  = 1'b0;
    endtask

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic cycle(input string tag, input bit check);
        bit    rx_e, tx_f, rd_ok, rd_stall, wr_ok, wr_stall, exp_rx_ready, exp_tx_valid;
        byte_t b;
        #2;
        rx_e         = (rx_q.size() == 0);
        tx_f         = (tx_q.size() == DEPTH);
        exp_rx_ready = (rx_q.size() < DEPTH) && !eof_seen_m;
        exp_tx_valid = (tx_q.size() > 0);
`ifdef IO_CONSOLE_ECHO_EN
        rd_ok    = ifc.in_read && !rx_e && !tx_f;
        rd_stall = ifc.in_read && (rx_e ? !eof_seen_m : tx_f);
        wr_ok    = ifc.out_write && !tx_f && !rd_ok;
`else
        rd_ok    = ifc.in_read && !rx_e;
        rd_stall = ifc.in_read && rx_e && !eof_seen_m;
        wr_ok    = ifc.out_write && !tx_f;
`endif
        wr_stall = ifc.out_write && !wr_ok;
        if (check) begin
            chk({tag, ".io_in"},    32'(ifc.io_in),    rx_e ? 32'd0 : 32'(rx_q[0]));
            chk({tag, ".eof"},      32'(ifc.eof),      32'(eof_seen_m && rx_e));
            chk({tag, ".io_busy"},  32'(ifc.io_busy),  32'(rd_stall || wr_stall));
            chk({tag, ".rx_ready"}, 32'(ifc.rx_ready), 32'(exp_rx_ready));
            chk({tag, ".tx_valid"}, 32'(ifc.tx_valid), 32'(exp_tx_valid));
            chk({tag, ".tx_data"},  32'(ifc.tx_data),  exp_tx_valid ? 32'(tx_q[0]) : 32'd0);
        end
        @(posedge clk);
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            eof_seen_m = 1'b0;
        end else begin
            if (exp_tx_valid && ifc.tx_ready) void'(tx_q.pop_front());
            if (rd_ok) begin
                b = rx_q.pop_front();
`ifdef IO_CONSOLE_ECHO_EN
                tx_q.push_back(b);
`endif
            end
            if (wr_ok) tx_q.push_back(ifc.io_out[7:0]);
            if (ifc.rx_valid && exp_rx_ready) rx_q.push_back(ifc.rx_data);
            if (ifc.rx_eof) eof_seen_m = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle("rst", 1'b0);
        cycle("rst_hold", 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        eof_seen_m = 1'b0;
        idle();

        // Reset, including a read request while held in reset.
        rst = 1'b1;
        cycle("rst0", 1'b0);
        cycle("rst1", 1'b1);
        ifc.in_read = 1'b1;
        #1 chk("rst_read_busy", 32'(ifc.io_busy), 32'd1);
        cycle("rst2", 1'b1);
        idle();
        cycle("post_rst", 1'b1);

        // Two bytes in, two reads out.
        ifc.rx_valid = 1'b1; ifc.rx_data = 8'h41; cycle("rx41", 1'b1);
        ifc.rx_data = 8'h42;                      cycle("rx42", 1'b1);
        idle(); ifc.in_read = 1'b1;
        #1 chk("rd41", 32'(ifc.io_in), 32'h41);
        cycle("rd1", 1'b1);
        #1 chk("rd42", 32'(ifc.io_in), 32'h42);
        cycle("rd2", 1'b1);
        idle();
        #1 chk("rx_empty_in", 32'(ifc.io_in), 32'h0);
        cycle("after_rd", 1'b1);

        // Read on empty stalls; a byte arriving later is then served.
        ifc.in_read = 1'b1;
        #1 chk("empty_busy", 32'(ifc.io_busy), 32'd1);
        cycle("empty_rd", 1'b1);
        idle(); ifc.rx_valid = 1'b1; ifc.rx_data = 8'h10; cycle("rx10", 1'b1);
        idle(); ifc.in_read = 1'b1;
        #1 chk("rd10", 32'(ifc.io_in), 32'h10);
        cycle("rd10c", 1'b1);
        idle();

        // TX fill to capacity with host stalled, then drain in order.
        for (int i = 0; i < 5; i++) begin
            ifc.out_write = 1'b1;
            ifc.io_out    = word_t'(16'h0161 + i);
            #1 chk($sformatf("wr_busy%0d", i), 32'(ifc.io_busy), (i == 4) ? 32'd1 : 32'd0);
            cycle($sformatf("wr%0d", i), 1'b1);
        end
        idle(); ifc.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("drain%0d", i), 32'(ifc.tx_data), 32'h61 + 32'(i));
            cycle($sformatf("drain_c%0d", i), 1'b1);
        end
        cycle("tx_empty", 1'b1);

        // RX full: pop and push in the same cycle; push only lands next cycle.
        idle(); ifc.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.rx_data = byte_t'(8'hB0 + i);
            cycle($sformatf("fill%0d", i), 1'b1);
        end
        ifc.in_read = 1'b1; ifc.rx_data = 8'hA5;
        #1 chk("full_rdy0", 32'(ifc.rx_ready), 32'd0);
        cycle("full_pop", 1'b1);
        ifc.in_read = 1'b0;
        #1 chk("refill_rdy", 32'(ifc.rx_ready), 32'd1);
        cycle("refill", 1'b1);
        idle(); ifc.tx_ready = 1'b1; ifc.in_read = 1'b1;
        for (int i = 0; i < 6; i++) cycle($sformatf("order%0d", i), 1'b1);
        idle(); cycle("order_end", 1'b1);

        // End of input: queued byte delivered before eof rises.
        ifc.rx_valid = 1'b1; ifc.rx_data = 8'h33; cycle("rx33", 1'b1);
        idle(); ifc.rx_eof = 1'b1; cycle("eof_pulse", 1'b1);
        idle();
        #1 chk("eof_pending", 32'(ifc.eof), 32'd0);
        ifc.in_read = 1'b1; ifc.tx_ready = 1'b1;
        cycle("rd33", 1'b1);
        #1 chk("eof_set", 32'(ifc.eof), 32'd1);
        chk("eof_rdy", 32'(ifc.rx_ready), 32'd0);
        chk("eof_in", 32'(ifc.io_in), 32'd0);
        chk("eof_busy", 32'(ifc.io_busy), 32'd0);
        cycle("eof_rd", 1'b1);
        do_reset();
        cycle("eof_clear", 1'b1);

        // Reset mid-transfer discards both FIFOs.
        ifc.rx_valid = 1'b1; ifc.rx_data = 8'h55;
        ifc.out_write = 1'b1; ifc.io_out = 16'hAB66;
        cycle("mid0", 1'b1);
        cycle("mid1", 1'b1);
        do_reset();
        #1 chk("mid_txv", 32'(ifc.tx_valid), 32'd0);
        chk("mid_in", 32'(ifc.io_in), 32'd0);
        cycle("mid_after", 1'b1);

`ifdef IO_CONSOLE_ECHO_EN
        // Echo: a read byte reappears on TX.
        ifc.rx_valid = 1'b1; ifc.rx_data = 8'h7A; cycle("rx7a", 1'b1);
        idle(); ifc.in_read = 1'b1;
        #1 chk("echo_in", 32'(ifc.io_in), 32'h7A);
        cycle("echo_rd", 1'b1);
        idle();
        #1 chk("echo_txv", 32'(ifc.tx_valid), 32'd1);
        chk("echo_txd", 32'(ifc.tx_data), 32'h7A);
        cycle("echo_after", 1'b1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            ifc.rx_valid  = $urandom_range(0, 1) == 1;
            ifc.rx_data   = byte_t'($urandom);
            ifc.rx_eof    = ($urandom_range(0, 79) == 0);
            ifc.in_read   = $urandom_range(0, 2) == 0;
            ifc.out_write = $urandom_range(0, 2) == 0;
            ifc.io_out    = word_t'($urandom);
            ifc.tx_ready  = $urandom_range(0, 1) == 1;
            cycle($sformatf("rnd%0d", n), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
